icache_refill_ctrl: RTL and testbench

Single-outstanding miss/refill sequencer for the 8KB 2-way icache. It accepts one miss from the fetch unit, issues a 32B block read to L2, captures the matching response, and writes the tag and data arrays of the chosen victim way. It then signals fill completion to fetch. It sits between the icache miss detection logic and the L2 request/response bus.

---
 rtl/icache_refill_ctrl.sv | 112 +++++++++++
 tb/tb_icache_refill_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// Single-outstanding icache miss/refill sequencer: one 32B L2 read per miss, then a tag/data write.
// Define ICACHE_REFILL_FWD_EN to forward the critical 16B chunk to fetch in the WRITE cycle.
module icache_refill_ctrl #(
    parameter int PA29_WIDTH  = 29,
    parameter int INDEX_WIDTH = 7,
    parameter int TAG_WIDTH   = 22,
    parameter int BLOCK_BITS  = 256,
    parameter int FETCH_BITS  = 128
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   miss_valid,
    output logic                   miss_ready,
    input  logic [PA29_WIDTH-1:0]  miss_PA29,
    input  logic                   miss_way,
    input  logic                   miss_fetch_offset,
    input  logic                   cancel,
    output logic                   l2_req_valid,
    input  logic                   l2_req_ready,
    output logic [PA29_WIDTH-1:0]  l2_req_PA29,
    input  logic                   l2_resp_valid,
    input  logic [PA29_WIDTH-1:0]  l2_resp_PA29,
    input  logic [BLOCK_BITS-1:0]  l2_resp_data,
    output logic                   tag_write_valid,
    output logic [INDEX_WIDTH-1:0] tag_write_index,
    output logic                   tag_write_way,
    output logic [TAG_WIDTH-1:0]   tag_write_tag,
    output logic                   data_write_valid,
    output logic [INDEX_WIDTH-1:0] data_write_index,
    output logic                   data_write_way,
    output logic [BLOCK_BITS-1:0]  data_write_data,
    output logic                   fill_done_valid,
    output logic [PA29_WIDTH-1:0]  fill_done_PA29,
    output logic                   fwd_valid,
    output logic [FETCH_BITS-1:0]  fwd_data,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

    state_t                 state;
    logic [PA29_WIDTH-1:0]  pa_q;
    logic                   way_q;
    logic                   off_q;
    logic                   cancelled_q;
    logic [BLOCK_BITS-1:0]  data_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= IDLE;
            pa_q        <= '0;
            way_q       <= 1'b0;
            off_q       <= 1'b0;
            cancelled_q <= 1'b0;
            data_q      <= '0;
        end else begin
            case (state)
                IDLE: if (miss_valid) begin
                    pa_q        <= miss_PA29;
                    way_q       <= miss_way;
                    off_q       <= miss_fetch_offset;
                    cancelled_q <= 1'b0;
                    state       <= REQ;
                end
                REQ: begin
                    // Once the request has been handed off, the response must still be drained.
                    if (l2_req_ready) begin
                        state <= WAIT;
                        if (cancel) cancelled_q <= 1'b1;
                    end else if (cancel) begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (cancel) cancelled_q <= 1'b1;
                    if (l2_resp_valid && l2_resp_PA29 == pa_q) begin
                        data_q <= l2_resp_data;
                        state  <= WRITE;
                    end
                end
                WRITE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign miss_ready       = (state == IDLE);
    assign busy             = (state != IDLE);
    assign l2_req_valid     = (state == REQ);
    assign l2_req_PA29      = pa_q;

    // Arrays are filled even for a cancelled miss; the block is still useful.
    assign tag_write_valid  = (state == WRITE);
    assign tag_write_index  = pa_q[INDEX_WIDTH-1:0];
    assign tag_write_way    = way_q;
    assign tag_write_tag    = pa_q[PA29_WIDTH-1:INDEX_WIDTH];
    assign data_write_valid = (state == WRITE);
    assign data_write_index = pa_q[INDEX_WIDTH-1:0];
    assign data_write_way   = way_q;
    assign data_write_data  = data_q;
    assign fill_done_valid  = (state == WRITE) && !cancelled_q && !cancel;
    assign fill_done_PA29   = pa_q;

`ifdef ICACHE_REFILL_FWD_EN
    assign fwd_valid = fill_done_valid;
    assign fwd_data  = off_q ? data_q[FETCH_BITS +: FETCH_BITS] : data_q[FETCH_BITS-1:0];
`else
    logic unused_off;
    assign unused_off = off_q;
    assign fwd_valid  = 1'b0;
    assign fwd_data   = '0;
`endif
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: directed misses push expected L2 requests and
// array writes into queues; negedge monitors pop and compare whenever the DUT presents them.
module tb_icache_refill_ctrl;
    logic         CLK = 1'b0;
    logic         nRST;
    logic         miss_valid, miss_ready, miss_way, miss_fetch_offset, cancel;
    logic [28:0]  miss_PA29;
    logic         l2_req_valid, l2_req_ready;
    logic [28:0]  l2_req_PA29;
    logic         l2_resp_valid;
    logic [28:0]  l2_resp_PA29;
    logic [255:0] l2_resp_data;
    logic         tag_write_valid, tag_write_way;
    logic [6:0]   tag_write_index;
    logic [21:0]  tag_write_tag;
    logic         data_write_valid, data_write_way;
    logic [6:0]   data_write_index;
    logic [255:0] data_write_data;
    logic         fill_done_valid;
    logic [28:0]  fill_done_PA29;
    logic         fwd_valid;
    logic [127:0] fwd_data;
    logic         busy;

    icache_refill_ctrl dut (
        .CLK(CLK), .nRST(nRST),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_PA29(miss_PA29),
        .miss_way(miss_way), .miss_fetch_offset(miss_fetch_offset), .cancel(cancel),
        .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_PA29(l2_req_PA29),
        .l2_resp_valid(l2_resp_valid), .l2_resp_PA29(l2_resp_PA29), .l2_resp_data(l2_resp_data),
        .tag_write_valid(tag_write_valid), .tag_write_index(tag_write_index),
        .tag_write_way(tag_write_way), .tag_write_tag(tag_write_tag),
        .data_write_valid(data_write_valid), .data_write_index(data_write_index),
        .data_write_way(data_write_way), .data_write_data(data_write_data),
        .fill_done_valid(fill_done_valid), .fill_done_PA29(fill_done_PA29),
        .fwd_valid(fwd_valid), .fwd_data(fwd_data), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [6:0]   idx;
        logic [21:0]  tag;
        logic         way;
        logic [255:0] data;
        logic         fill;
        logic [28:0]  pa;
        logic         fwd;
        logic [127:0] fwd_data;
    } wr_t;

    wr_t         wq[$];
    logic [28:0] rq[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Expected write record; fwd follows fill when forwarding is built in.
    function automatic wr_t mk(input logic [28:0] pa, input logic way, input logic off,
                               input logic [255:0] d, input logic fill);
        wr_t w;
        w.idx  = pa[6:0];
        w.tag  = pa[28:7];
        w.way  = way;
        w.data = d;
        w.fill = fill;
        w.pa   = pa;
`ifdef ICACHE_REFILL_FWD_EN
        w.fwd      = fill;
        w.fwd_data = off ? d[255:128] : d[127:0];
`else
        w.fwd      = 1'b0;
        w.fwd_data = '0;
`endif
        return w;
    endfunction

    // Request monitor
    always @(negedge CLK) begin
        if (nRST && l2_req_valid && l2_req_ready) begin
            if (rq.size() == 0) chk("unexpected_l2_handshake", 1, 0);
            else chk("l2_req_PA29", l2_req_PA29, rq.pop_front());
        end
    end

    // Array-write / fill monitor
    always @(negedge CLK) begin
        if (nRST && tag_write_valid) begin
            if (wq.size() == 0) chk("unexpected_array_write", 1, 0);
            else begin
                wr_t e;
                e = wq.pop_front();
                chk("tag_write_index", tag_write_index, e.idx);
                chk("tag_write_tag", tag_write_tag, e.tag);
                chk("tag_write_way", tag_write_way, e.way);
                chk("data_write_valid", data_write_valid, 1);
                chk("data_write_index", data_write_index, e.idx);
                chk("data_write_way", data_write_way, e.way);
                chk("data_write_data", data_write_data, e.data);
                chk("fill_done_valid", fill_done_valid, e.fill);
                if (e.fill) chk("fill_done_PA29", fill_done_PA29, e.pa);
                chk("fwd_valid", fwd_valid, e.fwd);
                if (e.fwd) chk("fwd_data", fwd_data, e.fwd_data);
            end
        end else if (nRST && (data_write_valid || fill_done_valid || fwd_valid)) begin
            chk("stray_write_or_fill", 1, 0);
        end
    end

    task automatic issue_miss(input logic [28:0] pa, input logic way, input logic off);
        miss_valid = 1'b1; miss_PA29 = pa; miss_way = way; miss_fetch_offset = off;
        chk("miss_ready_before_accept", miss_ready, 1);
        step();
        miss_valid = 1'b0;
    endtask

    task automatic respond(input logic [28:0] pa, input logic [255:0] d);
        l2_resp_valid = 1'b1; l2_resp_PA29 = pa; l2_resp_data = d;
        step();
        l2_resp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [255:0] d;
        nRST = 0; miss_valid = 0; miss_PA29 = 0; miss_way = 0; miss_fetch_offset = 0;
        cancel = 0; l2_req_ready = 0; l2_resp_valid = 0; l2_resp_PA29 = 0; l2_resp_data = 0;
        step(); step();
        chk("rst_miss_ready", miss_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_l2_req_valid", l2_req_valid, 0);
        chk("rst_l2_req_PA29", l2_req_PA29, 0);
        chk("rst_tag_write_valid", tag_write_valid, 0);
        chk("rst_fill_done_valid", fill_done_valid, 0);
        chk("rst_fwd_valid", fwd_valid, 0);
        chk("rst_fwd_data", fwd_data, 0);
        nRST = 1;
        step();

        // Basic refill, hand-computed index/tag for 0x0ABCDEF
        l2_req_ready = 1;
        rq.push_back(29'h0ABCDEF);
        issue_miss(29'h0ABCDEF, 1'b1, 1'b0);
        chk("basic_l2_req_valid_N1", l2_req_valid, 1);
        chk("basic_miss_ready_low", miss_ready, 0);
        step();
        l2_req_ready = 0;
        step(); step();
        d = {8{32'hDEADBEEF}};
        begin
            wr_t w;
            w = mk(29'h0ABCDEF, 1'b1, 1'b0, d, 1'b1);
            w.idx = 7'h6F; w.tag = 22'h01579B;
            wq.push_back(w);
        end
        respond(29'h0ABCDEF, d);
        chk("basic_miss_ready_M1", miss_ready, 0);
        step();
        chk("basic_miss_ready_M2", miss_ready, 1);

        // L2 stall: request held stable for 5 cycles, one handshake
        issue_miss(29'h1234567, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_l2_req_valid", l2_req_valid, 1);
            chk("stall_l2_req_PA29", l2_req_PA29, 29'h1234567);
            step();
        end
        rq.push_back(29'h1234567);
        l2_req_ready = 1;
        step();
        l2_req_ready = 0;
        chk("stall_wait_no_req", l2_req_valid, 0);
        d = {16{16'h5A3C}};
        wq.push_back(mk(29'h1234567, 1'b0, 1'b0, d, 1'b1));
        respond(29'h1234567, d);
        step();

        // Foreign response ignored, then matching one
        l2_req_ready = 1;
        rq.push_back(29'h0F0F0F0);
        issue_miss(29'h0F0F0F0, 1'b1, 1'b0);
        step();
        l2_req_ready = 0;
        respond(29'h0000001, {8{32'h11111111}});
        chk("foreign_no_write", tag_write_valid, 0);
        chk("foreign_still_busy", busy, 1);
        d = {8{32'h76543210}};
        wq.push_back(mk(29'h0F0F0F0, 1'b1, 1'b0, d, 1'b1));
        respond(29'h0F0F0F0, d);
        step();

        // Cancel in REQ before handshake: straight back to IDLE
        issue_miss(29'h0000055, 1'b0, 1'b0);
        cancel = 1;
        step();
        cancel = 0;
        chk("cancel_req_idle", miss_ready, 1);
        chk("cancel_req_busy", busy, 0);
        step();

        // Cancel in WAIT: arrays written, no fill_done
        l2_req_ready = 1;
        rq.push_back(29'h1FFFFFF);
        issue_miss(29'h1FFFFFF, 1'b1, 1'b1);
        step();
        l2_req_ready = 0;
        cancel = 1;
        step();
        cancel = 0;
        d = {4{64'h0123456789ABCDEF}};
        wq.push_back(mk(29'h1FFFFFF, 1'b1, 1'b1, d, 1'b0));
        respond(29'h1FFFFFF, d);
        step();

        // Cancel together with handshake: still consumes response, no fill_done
        l2_req_ready = 1;
        rq.push_back(29'h0000100);
        issue_miss(29'h0000100, 1'b0, 1'b0);
        cancel = 1;
        step();
        cancel = 0; l2_req_ready = 0;
        chk("cancel_hs_wait", busy, 1);
        d = {8{32'hCAFEF00D}};
        wq.push_back(mk(29'h0000100, 1'b0, 1'b0, d, 1'b0));
        respond(29'h0000100, d);
        step();

        // Miss with simultaneous cancel in IDLE is accepted normally
        l2_req_ready = 1;
        rq.push_back(29'h0000200);
        miss_valid = 1; miss_PA29 = 29'h0000200; miss_way = 1; miss_fetch_offset = 0; cancel = 1;
        step();
        miss_valid = 0; cancel = 0;
        chk("idle_cancel_miss_accepted", l2_req_valid, 1);
        step();
        l2_req_ready = 0;
        d = {8{32'h0BADC0DE}};
        wq.push_back(mk(29'h0000200, 1'b1, 1'b0, d, 1'b1));
        respond(29'h0000200, d);
        step();

        // Reset in WAIT, then a late matching response: ignored
        l2_req_ready = 1;
        rq.push_back(29'h0333333);
        issue_miss(29'h0333333, 1'b0, 1'b0);
        step();
        l2_req_ready = 0;
        nRST = 0;
        step();
        nRST = 1;
        respond(29'h0333333, {8{32'hFFFFFFFF}});
        chk("rst_wait_no_write", tag_write_valid, 0);
        chk("rst_wait_no_fill", fill_done_valid, 0);
        chk("rst_wait_miss_ready", miss_ready, 1);
        step();

        // Critical-chunk forward, upper half requested
        l2_req_ready = 1;
        rq.push_back(29'h0044444);
        issue_miss(29'h0044444, 1'b1, 1'b1);
        step();
        l2_req_ready = 0;
        d = {{16{8'hA5}}, {16{8'h3C}}};
        wq.push_back(mk(29'h0044444, 1'b1, 1'b1, d, 1'b1));
        respond(29'h0044444, d);
        step();
        step();

        chk("write_queue_drained", wq.size(), 0);
        chk("req_queue_drained", rq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
